gf_pixel_alu: RTL and testbench

Parametrised per-pixel arithmetic engine for the guided-filter pipeline. Streams one full frame of two operand RAMs (A, B) through a selectable fixed-point operation and writes the saturated result to RAM C, under a start/busy/done handshake. It generalises the b-coefficient pass (b = mean_p − a·mean_I) to configurable image size, data width, fraction bits and RAM read latency, and adds multiply, add and subtract modes, so the a, b and q = a·I + b stages share one block.

---
 rtl/gf_pkg.sv | 37 +++
 rtl/gf_alu.sv | 54 +++++
 rtl/gf_pixel_alu.sv | 136 +++++++++++++
 tb/tb_gf_pixel_alu.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/gf_pkg.sv
// Shared types and the saturation helper for the guided-filter pixel ALU.
// Widths are sized for the widest data path the ALU supports (GF_MAX_DW).
package gf_pkg;

  localparam int GF_MAX_DW = 48;
  localparam int GF_WIDE_W = 2 * GF_MAX_DW + 4;

  typedef enum logic [1:0] {
    OP_BCOEF = 2'd0,
    OP_MUL   = 2'd1,
    OP_SUB   = 2'd2,
    OP_ADD   = 2'd3
  } opT;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } stateT;

  // Clamp a signed intermediate into the unsigned range [0, 2^dw-1].
  function automatic logic [GF_MAX_DW-1:0] saturate(
    input logic signed [GF_WIDE_W-1:0] val,
    input int                          dw
  );
    logic signed [GF_WIDE_W-1:0] maxVal;
    maxVal = signed'((GF_WIDE_W'(1) << dw) - GF_WIDE_W'(1));
    if (val[GF_WIDE_W-1])
      saturate = '0;
    else if (val > maxVal)
      saturate = maxVal[GF_MAX_DW-1:0];
    else
      saturate = val[GF_MAX_DW-1:0];
  endfunction

endpackage

// File: rtl/gf_alu.sv
// One-stage fixed-point ALU: computes the selected operation in a signed
// 2*DW+2 bit intermediate and registers the saturated DW-bit result.
module gf_alu
  import gf_pkg::*;
#(
  parameter int DW   = 24,
  parameter int FRAC = 7
) (
  input  logic          iCLK,
  input  logic          iRST_N,
  input  opT            opSel,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] result
);

  localparam int IW = 2 * DW + 2;

  logic signed [IW-1:0]        aExt;
  logic signed [IW-1:0]        bExt;
  logic signed [IW-1:0]        prod;
  logic signed [IW-1:0]        rawVal;
  logic signed [GF_WIDE_W-1:0] wideVal;
  logic [GF_MAX_DW-1:0]        satFull;
  logic                        unusedSat;

  assign aExt = signed'({{(IW-DW){1'b0}}, a});
  assign bExt = signed'({{(IW-DW){1'b0}}, b});
  assign prod = aExt * bExt;

  // Operands are non-negative, so the arithmetic MUL shift is a floor.
  always_comb begin
    rawVal = '0;
    case (opSel)
      OP_BCOEF: rawVal = (aExt <<< FRAC) - prod;
      OP_MUL:   rawVal = prod >>> FRAC;
      OP_SUB:   rawVal = aExt - bExt;
      OP_ADD:   rawVal = aExt + bExt;
      default:  rawVal = '0;
    endcase
  end

  assign wideVal   = {{(GF_WIDE_W-IW){rawVal[IW-1]}}, rawVal};
  assign satFull   = saturate(wideVal, DW);
  assign unusedSat = &{1'b0, satFull};

  always_ff @(posedge iCLK) begin
    if (!iRST_N)
      result <= '0;
    else
      result <= satFull[DW-1:0];
  end

endmodule

// File: rtl/gf_pixel_alu.sv
// Frame-streaming pixel ALU: reads A/B at one address per cycle, pushes
// them through gf_alu and writes the saturated result to RAM C.
module gf_pixel_alu
  import gf_pkg::*;
#(
  parameter int IMG_W  = 300,
  parameter int IMG_H  = 210,
  parameter int DW     = 24,
  parameter int FRAC   = 7,
  parameter int AW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic          iCLK,
  input  logic          iRST_N,
  input  logic          start,
  input  logic [1:0]    op_sel,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] iAddrA,
  output logic [AW-1:0] iAddrB,
  input  logic [DW-1:0] oDataA,
  input  logic [DW-1:0] oDataB,
  output logic          wrenA,
  output logic          wrenB,
  output logic          wrenC,
  output logic [AW-1:0] iAddrC,
  output logic [DW-1:0] iDataC
);

  localparam int N = IMG_W * IMG_H;
  localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);
  localparam int DRAIN_W = $clog2(RD_LAT + 2);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(RD_LAT);

  stateT                state;
  stateT                nextState;
  logic [AW-1:0]        rdAddr;
  logic [DRAIN_W-1:0]   drainCnt;
  opT                   opLatched;
  logic                 issue;
  logic [RD_LAT:0]      validPipe;
  logic [AW-1:0]        addrPipe [RD_LAT:0];
  logic [DW-1:0]        aluResult;

  always_ff @(posedge iCLK) begin
    if (!iRST_N)
      state <= S_IDLE;
    else
      state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      S_IDLE:  if (start) nextState = S_RUN;
      S_RUN:   if (rdAddr == LAST_ADDR) nextState = S_DRAIN;
      S_DRAIN: if (drainCnt == DRAIN_LAST) nextState = S_DONE;
      S_DONE:  nextState = S_IDLE;
      default: nextState = S_IDLE;
    endcase
  end

  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    issue = 1'b0;
    case (state)
      S_RUN:   begin busy = 1'b1; issue = 1'b1; end
      S_DRAIN: busy = 1'b1;
      S_DONE:  begin busy = 1'b1; done = 1'b1; end
      default: ;
    endcase
  end

  // Address counter parks at 0 outside RUN; op is captured only with an accepted start.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      rdAddr    <= '0;
      drainCnt  <= '0;
      opLatched <= OP_BCOEF;
    end else begin
      case (state)
        S_IDLE: begin
          rdAddr   <= '0;
          drainCnt <= '0;
          if (start) opLatched <= opT'(op_sel);
        end
        S_RUN: begin
          rdAddr   <= (rdAddr == LAST_ADDR) ? '0 : rdAddr + AW'(1);
          drainCnt <= '0;
        end
        S_DRAIN: begin
          rdAddr   <= '0;
          drainCnt <= drainCnt + DRAIN_W'(1);
        end
        default: begin
          rdAddr   <= '0;
          drainCnt <= '0;
        end
      endcase
    end
  end

  // RD_LAT stages cover the RAM, the extra stage covers the ALU register.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      validPipe <= '0;
      for (int i = 0; i <= RD_LAT; i++) addrPipe[i] <= '0;
    end else begin
      validPipe   <= {validPipe[RD_LAT-1:0], issue};
      addrPipe[0] <= rdAddr;
      for (int i = 1; i <= RD_LAT; i++) addrPipe[i] <= addrPipe[i-1];
    end
  end

  gf_alu #(
    .DW   (DW),
    .FRAC (FRAC)
  ) uAlu (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .opSel  (opLatched),
    .a      (oDataA),
    .b      (oDataB),
    .result (aluResult)
  );

  assign iAddrA = rdAddr;
  assign iAddrB = rdAddr;
  assign wrenA  = 1'b0;
  assign wrenB  = 1'b0;
  assign wrenC  = validPipe[RD_LAT];
  assign iAddrC = addrPipe[RD_LAT];
  assign iDataC = wrenC ? aluResult : '0;

endmodule

// File: tb/tb_gf_pixel_alu.sv
// Directed bench for gf_pixel_alu: a 4x2 frame with RD_LAT=1 and RD_LAT=3
// instances sharing stimulus, RAM models and a per-frame write recorder.
module tb_gf_pixel_alu;

  logic        clk;
  logic        rstN;
  logic        start;
  logic [1:0]  opSel;
  logic        sel3;

  logic        busy1, done1, wrenA1, wrenB1, wrenC1;
  logic [15:0] addrA1, addrB1, addrC1;
  logic [23:0] dataA1, dataB1, dataC1;
  logic        busy3, done3, wrenA3, wrenB3, wrenC3;
  logic [15:0] addrA3, addrB3, addrC3;
  logic [23:0] dataA3, dataB3, dataC3;

  logic [23:0] memA [0:255];
  logic [23:0] memB [0:255];
  logic [23:0] rdA1, rdB1;
  logic [23:0] pA3 [0:2];
  logic [23:0] pB3 [0:2];

  logic        obsBusy, obsDone, obsWren;
  logic [15:0] obsAddrA, obsAddrC;
  logic [23:0] obsDataC;

  int          vecCount;
  int          missCount;
  int          wrCount, doneCount, busyFirst, busyLast, busyCount;
  int          wrAddr [0:63];
  int          wrCycle [0:63];
  logic [23:0] wrData [0:63];
  int          doneAt [0:3];
  int          rdAddrAt [0:63];

  gf_pixel_alu #(.IMG_W(4), .IMG_H(2), .DW(24), .FRAC(7), .AW(16), .RD_LAT(1)) dut (
    .iCLK(clk), .iRST_N(rstN), .start(start), .op_sel(opSel),
    .busy(busy1), .done(done1), .iAddrA(addrA1), .iAddrB(addrB1),
    .oDataA(dataA1), .oDataB(dataB1), .wrenA(wrenA1), .wrenB(wrenB1),
    .wrenC(wrenC1), .iAddrC(addrC1), .iDataC(dataC1)
  );

  gf_pixel_alu #(.IMG_W(4), .IMG_H(2), .DW(24), .FRAC(7), .AW(16), .RD_LAT(3)) dut3 (
    .iCLK(clk), .iRST_N(rstN), .start(start), .op_sel(opSel),
    .busy(busy3), .done(done3), .iAddrA(addrA3), .iAddrB(addrB3),
    .oDataA(dataA3), .oDataB(dataB3), .wrenA(wrenA3), .wrenB(wrenB3),
    .wrenC(wrenC3), .iAddrC(addrC3), .iDataC(dataC3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM models with one and three cycles of read latency.
  always @(posedge clk) begin
    rdA1   <= memA[addrA1[7:0]];
    rdB1   <= memB[addrB1[7:0]];
    pA3[0] <= memA[addrA3[7:0]];
    pB3[0] <= memB[addrB3[7:0]];
    pA3[1] <= pA3[0];
    pB3[1] <= pB3[0];
    pA3[2] <= pA3[1];
    pB3[2] <= pB3[1];
  end
  assign dataA1 = rdA1;
  assign dataB1 = rdB1;
  assign dataA3 = pA3[2];
  assign dataB3 = pB3[2];

  assign obsBusy  = sel3 ? busy3  : busy1;
  assign obsDone  = sel3 ? done3  : done1;
  assign obsWren  = sel3 ? wrenC3 : wrenC1;
  assign obsAddrA = sel3 ? addrA3 : addrA1;
  assign obsAddrC = sel3 ? addrC3 : addrC1;
  assign obsDataC = sel3 ? dataC3 : dataC1;

  task automatic fillMem(input logic [23:0] aVal, input logic [23:0] bVal, input bit ramp);
    for (int i = 0; i < 256; i++) begin
      memA[i] = ramp ? 24'(i) : aVal;
      memB[i] = bVal;
    end
  endtask

  // Cycle 0 is the cycle that carries start; called #1 after a posedge.
  task automatic runFrame(input logic [1:0] op, input int cycles, input int repulseAt,
                          input logic [1:0] repulseOp, input int resetAt);
    wrCount = 0; doneCount = 0; busyFirst = -1; busyLast = -1; busyCount = 0;
    for (int i = 0; i < 4; i++) doneAt[i] = -1;
    for (int c = 0; c < cycles; c++) begin
      start = (c == 0) || (c == repulseAt);
      opSel = (c == repulseAt) ? repulseOp : op;
      rstN  = (c != resetAt);
      @(negedge clk);
      if (c < 64) rdAddrAt[c] = int'(obsAddrA);
      if (obsWren && wrCount < 64) begin
        wrAddr[wrCount]  = int'(obsAddrC);
        wrData[wrCount]  = obsDataC;
        wrCycle[wrCount] = c;
        wrCount++;
      end
      if (obsBusy) begin
        if (busyFirst < 0) busyFirst = c;
        busyLast = c;
        busyCount++;
      end
      if (obsDone) begin
        if (doneCount < 4) doneAt[doneCount] = c;
        doneCount++;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    rstN  = 1'b1;
  endtask

  task automatic test_reset;
    rstN = 1'b0; start = 1'b0; opSel = 2'd0; sel3 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vecCount++; if (busy1 !== 1'b0) begin missCount++; $display("[TB] FAIL reset_busy: got %b want 0", busy1); end
    vecCount++; if (done1 !== 1'b0) begin missCount++; $display("[TB] FAIL reset_done: got %b want 0", done1); end
    vecCount++; if (wrenC1 !== 1'b0) begin missCount++; $display("[TB] FAIL reset_wrenC: got %b want 0", wrenC1); end
    vecCount++; if (addrA1 !== 16'd0) begin missCount++; $display("[TB] FAIL reset_addrA: got %0d want 0", addrA1); end
    vecCount++; if (addrC1 !== 16'd0) begin missCount++; $display("[TB] FAIL reset_addrC: got %0d want 0", addrC1); end
    vecCount++; if (dataC1 !== 24'd0) begin missCount++; $display("[TB] FAIL reset_dataC: got %0d want 0", dataC1); end
    vecCount++; if ({wrenA1, wrenB1} !== 2'b00) begin missCount++; $display("[TB] FAIL reset_wrenAB: got %b want 00", {wrenA1, wrenB1}); end
    vecCount++; if (busy3 !== 1'b0) begin missCount++; $display("[TB] FAIL reset_busy3: got %b want 0", busy3); end
    rstN = 1'b1;
    @(posedge clk); #1;
    vecCount++; if (busy1 !== 1'b0) begin missCount++; $display("[TB] FAIL idle_busy: got %b want 0", busy1); end
  endtask

  task automatic test_bcoef_frame;
    fillMem(24'd10, 24'd3, 1'b0);
    runFrame(2'd0, 16, -1, 2'd0, -1);
    vecCount++; if (wrCount !== 8) begin missCount++; $display("[TB] FAIL bcoef_count: got %0d want 8", wrCount); end
    for (int i = 0; i < 8; i++) begin
      vecCount++; if (wrAddr[i] !== i) begin missCount++; $display("[TB] FAIL bcoef_addr[%0d]: got %0d want %0d", i, wrAddr[i], i); end
      vecCount++; if (wrData[i] !== 24'd1250) begin missCount++; $display("[TB] FAIL bcoef_data[%0d]: got %0d want 1250", i, wrData[i]); end
      vecCount++; if (wrCycle[i] !== 3 + i) begin missCount++; $display("[TB] FAIL bcoef_cycle[%0d]: got %0d want %0d", i, wrCycle[i], 3 + i); end
    end
    for (int c = 1; c <= 8; c++) begin
      vecCount++; if (rdAddrAt[c] !== c - 1) begin missCount++; $display("[TB] FAIL rd_addr[%0d]: got %0d want %0d", c, rdAddrAt[c], c - 1); end
    end
    vecCount++; if (rdAddrAt[9] !== 0) begin missCount++; $display("[TB] FAIL rd_addr_drain: got %0d want 0", rdAddrAt[9]); end
    vecCount++; if (doneAt[0] !== 11) begin missCount++; $display("[TB] FAIL bcoef_done: got %0d want 11", doneAt[0]); end
    vecCount++; if (doneCount !== 1) begin missCount++; $display("[TB] FAIL bcoef_done_pulses: got %0d want 1", doneCount); end
    vecCount++; if (busyFirst !== 1) begin missCount++; $display("[TB] FAIL busy_first: got %0d want 1", busyFirst); end
    vecCount++; if (busyLast !== 11) begin missCount++; $display("[TB] FAIL busy_last: got %0d want 11", busyLast); end
    vecCount++; if (busyCount !== 11) begin missCount++; $display("[TB] FAIL busy_count: got %0d want 11", busyCount); end
  endtask

  task automatic test_ops;
    logic [23:0] aTab [0:7];
    logic [23:0] bTab [0:7];
    logic [1:0]  oTab [0:7];
    logic [23:0] eTab [0:7];
    aTab = '{24'd1,   24'd5, 24'd256, 24'hFFFFFF, 24'd9, 24'd100, 24'd3,   24'd2};
    bTab = '{24'd200, 24'd9, 24'd384, 24'hFFFFFF, 24'd5, 24'd23,  24'd100, 24'd64};
    oTab = '{2'd0,    2'd2,  2'd1,    2'd3,       2'd2,  2'd3,    2'd1,    2'd0};
    eTab = '{24'd0,   24'd0, 24'd768, 24'hFFFFFF, 24'd4, 24'd123, 24'd2,   24'd128};
    for (int t = 0; t < 8; t++) begin
      fillMem(aTab[t], bTab[t], 1'b0);
      runFrame(oTab[t], 16, -1, 2'd0, -1);
      vecCount++; if (wrCount !== 8) begin missCount++; $display("[TB] FAIL op%0d_count: got %0d want 8", t, wrCount); end
      vecCount++; if (wrData[0] !== eTab[t]) begin missCount++; $display("[TB] FAIL op%0d_first: got %0d want %0d", t, wrData[0], eTab[t]); end
      vecCount++; if (wrData[7] !== eTab[t]) begin missCount++; $display("[TB] FAIL op%0d_last: got %0d want %0d", t, wrData[7], eTab[t]); end
    end
  endtask

  task automatic test_latency3;
    fillMem(24'd0, 24'd128, 1'b1);
    sel3 = 1'b1;
    runFrame(2'd1, 16, -1, 2'd0, -1);
    sel3 = 1'b0;
    vecCount++; if (wrCount !== 8) begin missCount++; $display("[TB] FAIL lat3_count: got %0d want 8", wrCount); end
    for (int i = 0; i < 8; i++) begin
      vecCount++; if (wrData[i] !== 24'(i)) begin missCount++; $display("[TB] FAIL lat3_data[%0d]: got %0d want %0d", i, wrData[i], i); end
      vecCount++; if (wrCycle[i] !== 5 + i) begin missCount++; $display("[TB] FAIL lat3_cycle[%0d]: got %0d want %0d", i, wrCycle[i], 5 + i); end
    end
    vecCount++; if (doneAt[0] !== 13) begin missCount++; $display("[TB] FAIL lat3_done: got %0d want 13", doneAt[0]); end
    vecCount++; if (busyLast !== 13) begin missCount++; $display("[TB] FAIL lat3_busy_last: got %0d want 13", busyLast); end
  endtask

  task automatic test_restart_ignored;
    fillMem(24'd10, 24'd3, 1'b0);
    runFrame(2'd0, 16, 4, 2'd3, -1);
    vecCount++; if (wrCount !== 8) begin missCount++; $display("[TB] FAIL ignore_count: got %0d want 8", wrCount); end
    for (int i = 0; i < 8; i++) begin
      vecCount++; if (wrData[i] !== 24'd1250) begin missCount++; $display("[TB] FAIL ignore_data[%0d]: got %0d want 1250", i, wrData[i]); end
    end
    vecCount++; if (doneAt[0] !== 11) begin missCount++; $display("[TB] FAIL ignore_done: got %0d want 11", doneAt[0]); end
    vecCount++; if (doneCount !== 1) begin missCount++; $display("[TB] FAIL ignore_pulses: got %0d want 1", doneCount); end
  endtask

  task automatic test_back_to_back;
    fillMem(24'd10, 24'd3, 1'b0);
    runFrame(2'd0, 30, 12, 2'd3, -1);
    vecCount++; if (wrCount !== 16) begin missCount++; $display("[TB] FAIL b2b_count: got %0d want 16", wrCount); end
    for (int i = 0; i < 8; i++) begin
      vecCount++; if (wrData[8 + i] !== 24'd13) begin missCount++; $display("[TB] FAIL b2b_data[%0d]: got %0d want 13", i, wrData[8 + i]); end
      vecCount++; if (wrCycle[8 + i] !== 15 + i) begin missCount++; $display("[TB] FAIL b2b_cycle[%0d]: got %0d want %0d", i, wrCycle[8 + i], 15 + i); end
      vecCount++; if (wrAddr[8 + i] !== i) begin missCount++; $display("[TB] FAIL b2b_addr[%0d]: got %0d want %0d", i, wrAddr[8 + i], i); end
    end
    vecCount++; if (wrData[7] !== 24'd1250) begin missCount++; $display("[TB] FAIL b2b_first_frame: got %0d want 1250", wrData[7]); end
    vecCount++; if (doneCount !== 2) begin missCount++; $display("[TB] FAIL b2b_pulses: got %0d want 2", doneCount); end
    vecCount++; if (doneAt[1] !== 23) begin missCount++; $display("[TB] FAIL b2b_done2: got %0d want 23", doneAt[1]); end
  endtask

  task automatic test_reset_midframe;
    fillMem(24'd10, 24'd3, 1'b0);
    runFrame(2'd0, 16, -1, 2'd0, 6);
    vecCount++; if (wrCount !== 4) begin missCount++; $display("[TB] FAIL abort_count: got %0d want 4", wrCount); end
    for (int i = 0; i < 4 && i < wrCount; i++) begin
      vecCount++; if (wrAddr[i] !== i) begin missCount++; $display("[TB] FAIL abort_addr[%0d]: got %0d want %0d", i, wrAddr[i], i); end
    end
    vecCount++; if (busyLast !== 6) begin missCount++; $display("[TB] FAIL abort_busy_last: got %0d want 6", busyLast); end
    vecCount++; if (doneCount !== 0) begin missCount++; $display("[TB] FAIL abort_done: got %0d want 0", doneCount); end
    runFrame(2'd0, 16, -1, 2'd0, -1);
    vecCount++; if (wrCount !== 8) begin missCount++; $display("[TB] FAIL after_abort_count: got %0d want 8", wrCount); end
    vecCount++; if (doneAt[0] !== 11) begin missCount++; $display("[TB] FAIL after_abort_done: got %0d want 11", doneAt[0]); end
  endtask

  initial begin
    vecCount  = 0;
    missCount = 0;
    test_reset();
    test_bcoef_frame();
    test_ops();
    test_latency3();
    test_restart_ignored();
    test_back_to_back();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
